// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit loads/stores as two 16-bit SRAM half-word accesses. Optional MEM_ALIGN_CHECK_EN rejects bad addresses.
// Latency: 2*WAIT_CYCLES+1 frozen cycles plus one DONE cycle per access; non-memory instructions add none.
// Backpressure: freeze stalls every upstream register while an access is in flight; MEM/WB loads only when it is low.
module mem_stage_sram #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_ENIn,
  input  logic        MEM_R_ENIn,
  input  logic        MEM_W_ENIn,
  input  logic [31:0] ALU_ResIn,
  input  logic [31:0] Val_RmIn,
  input  logic [3:0]  DestIn,
  output logic        WB_ENOut,
  output logic        MEM_R_ENOut,
  output logic [31:0] ALU_ResOut,
  output logic [3:0]  DestOut,
  output logic [31:0] memDataOut,
  output logic        freeze,
  output logic        misalignErr,
  output logic [17:0] sramAddr,
  output logic [15:0] sramWData,
  input  logic [15:0] sramRData,
  output logic        sramWE_N,
  output logic        sramOE_N
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [7:0]  wait_cnt;
  logic [15:0] lo_stage;
  logic [15:0] lo_reg;
  logic [15:0] hi_reg;
  logic        req;
  logic        is_wr;
  logic        is_rd;
  logic        bad_addr;
  logic        last_cyc;
  logic        in_access;
  logic [16:0] word_idx;

  assign req       = MEM_R_ENIn | MEM_W_ENIn;
  assign is_wr     = MEM_W_ENIn;
  assign is_rd     = MEM_R_ENIn & ~MEM_W_ENIn;
  assign word_idx  = 17'((ALU_ResIn - 32'(BASE_ADDR)) >> 2);
  assign last_cyc  = (wait_cnt == 8'(WAIT_CYCLES - 1));
  assign in_access = (state == S_LOW) || (state == S_HIGH);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  assign bad_addr = (ALU_ResIn[1:0] != 2'b00) || (ALU_ResIn < 32'(BASE_ADDR));

  // err_q is set on the IDLE->DONE shortcut, so it is only high while in that DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && req && bad_addr;
    end
  end

  assign misalignErr = (state == S_DONE) && err_q;
`else
  assign bad_addr    = 1'b0;
  assign misalignErr = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = bad_addr ? S_DONE : S_LOW;
      S_LOW:   if (last_cyc) state_nxt = S_HIGH;
      S_HIGH:  if (last_cyc) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || !in_access) begin
        wait_cnt <= 8'd0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // The low half is staged so memDataOut only changes when the whole word is in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_stage <= 16'd0;
      lo_reg   <= 16'd0;
      hi_reg   <= 16'd0;
    end else if (is_rd && last_cyc) begin
      if (state == S_LOW) begin
        lo_stage <= sramRData;
      end else if (state == S_HIGH) begin
        hi_reg <= sramRData;
        lo_reg <= lo_stage;
      end
    end
  end

  always_comb begin
    sramAddr  = 18'd0;
    sramWData = 16'd0;
    sramWE_N  = 1'b1;
    sramOE_N  = 1'b1;
    if (in_access) begin
      sramAddr = {word_idx, (state == S_HIGH)};
      if (is_wr) begin
        sramWE_N  = 1'b0;
        sramWData = (state == S_HIGH) ? Val_RmIn[31:16] : Val_RmIn[15:0];
      end else begin
        sramOE_N = 1'b0;
      end
    end
  end

  assign freeze      = ((state == S_IDLE) && req) || in_access;
  assign memDataOut  = {hi_reg, lo_reg};
  assign WB_ENOut    = WB_ENIn;
  assign MEM_R_ENOut = MEM_R_ENIn;
  assign ALU_ResOut  = ALU_ResIn;
  assign DestOut     = DestIn;

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage of the ARM pipeline. Consumes the EXE stage results held in the EXE/MEM register (ALU result as byte address, Rm value as store data, WB/MEM controls, destination) and performs 32-bit loads and stores on an external 16-bit SRAM as two half-word accesses. It drives a `freeze` signal that stalls all upstream pipeline registers while an access is in flight. It forwards the load word and write-back controls to the MEM/WB register.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM half-word 0.
- `WAIT_CYCLES`, 1: cycles each half-word access is held on the SRAM pins (≥1).

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `WB_ENIn`  in  1  write-back enable from EXE/MEM.
- `MEM_R_ENIn`  in  1  load request.
- `MEM_W_ENIn`  in  1  store request.
- `ALU_ResIn`  in  32  byte address for loads/stores; write-back value otherwise.
- `Val_RmIn`  in  32  store data.
- `DestIn`  in  4  destination register.
- `WB_ENOut`  out  1  `WB_ENIn` passed through.
- `MEM_R_ENOut`  out  1  `MEM_R_ENIn` passed through.
- `ALU_ResOut`  out  32  `ALU_ResIn` passed through.
- `DestOut`  out  4  `DestIn` passed through.
- `memDataOut`  out  32  assembled load word; valid in DONE.
- `freeze`  out  1  stall request to PC, IF/ID, ID/EXE, EXE/MEM; MEM/WB loads only when low.
- `misalignErr`  out  1  one-cycle error pulse (see Configuration).
- `sramAddr`  out  18  SRAM half-word address.
- `sramWData`  out  16  SRAM write data.
- `sramRData`  in  16  SRAM read data.
- `sramWE_N`  out  1  SRAM write strobe, active-low.
- `sramOE_N`  out  1  SRAM output enable, active-low.

## Operation
- Request: `req = MEM_R_ENIn | MEM_W_ENIn`. If both are set, the access is a write and `memDataOut` is not updated.
- Address mapping:
  - `wordIdx = (ALU_ResIn - BASE_ADDR) >> 2`, 32-bit subtract, truncated to 17 bits.
  - Low half-word at `{wordIdx, 1'b0}`; high half-word at `{wordIdx, 1'b1}`.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE → LOW when `req`.
  - LOW → HIGH after `WAIT_CYCLES` cycles.
  - HIGH → DONE after `WAIT_CYCLES` cycles.
  - DONE → IDLE unconditionally.
- Wait counter: 8-bit, cleared on every state entry.
- `freeze` is combinational: `(IDLE & req) | LOW | HIGH`. It is low in DONE, so the instruction leaves the stage at the end of DONE and IDLE never re-triggers on it.
- LOW state:
  - `sramAddr` = low address.
  - Write: `sramWData = Val_RmIn[15:0]`, `sramWE_N = 0`.
  - Read: `sramOE_N = 0`; `sramRData` is latched into `loReg` on the last LOW cycle.
- HIGH state: same as LOW with the high address and `Val_RmIn[31:16]`; reads latch into `hiReg`.
- Outside LOW/HIGH: `sramWE_N = 1`, `sramOE_N = 1`, `sramAddr = 0`, `sramWData = 0`.
- `memDataOut = {hiReg, loReg}`. It holds its value until the next read completes.
- Reset values: state IDLE, counter 0, `hiReg`/`loReg` 0, `freeze` 0 (absent `req`), `sramWE_N` 1, `sramOE_N` 1, `misalignErr` 0. Pass-through outputs follow their inputs.
- Reset mid-access: the FSM returns to IDLE immediately. A partial write may leave only the low half written; no retry is made.

## Timing
- Access latency: `2*WAIT_CYCLES + 1` frozen cycles, then one DONE cycle. With `WAIT_CYCLES=1`, request at cycle 0 gives freeze high in cycles 0–2 and DONE in cycle 3.
- Non-memory instruction: zero added latency; `freeze` stays low.
- `sramWE_N` low exactly `WAIT_CYCLES` cycles per half-word; address and data are stable during the whole strobe.
- Back-to-back memory instructions: DONE → IDLE → LOW, giving one unfrozen cycle between accesses.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - An access with `ALU_ResIn[1:0] != 0` or `ALU_ResIn < BASE_ADDR` skips LOW/HIGH and goes IDLE → DONE.
  - `freeze` is high for one cycle, `misalignErr` pulses high in DONE, and the SRAM is untouched. `memDataOut` keeps its old value.
- `MEM_ALIGN_CHECK_EN` undefined: `ALU_ResIn[1:0]` is ignored, every access proceeds, and `misalignErr` is tied 0.

## Test plan
- Store `Val_RmIn=0xDEADBEEF` at address 1028, `WAIT_CYCLES=1`: half-word 2 gets 0xBEEF, half-word 3 gets 0xDEAD, `sramWE_N` low one cycle each, `freeze` high 3 cycles.
- Load from 1028 with SRAM model returning that data: `memDataOut=0xDEADBEEF` in DONE; `freeze` low in DONE.
- ALU instruction with no memory request: `freeze` stays 0 and outputs equal inputs every cycle.
- `WAIT_CYCLES=3` load: `freeze` high 7 cycles; `sramOE_N` low 6 cycles; address switches after 3.
- `rst` asserted in HIGH of a store: state IDLE, `sramWE_N`=1, `freeze`=0 immediately; only half-word low was written.
- With `MEM_ALIGN_CHECK_EN`, load from 1030: no SRAM strobe, `misalignErr` pulse one cycle, `freeze` 1 cycle.
